// File: rtl/usbreceiver.sv
// FT2232 asynchronous-FIFO receive path: strobes bytes into a circular buffer and presents them via valid/rd.
// Define USBRX_SYNC_EN to pass usb_rxf_n through a two-flop synchronizer before the IDLE decision.
module usbreceiver #(
  parameter int FIFO_LOG_SIZE = 13,
  parameter int RD_PULSE      = 4,
  parameter int RD_GAP        = 4
) (
  input  logic                     mclk,
  input  logic                     reset,
  input  logic [7:0]               usb_d,
  input  logic                     usb_rxf_n,
  output logic                     usb_rd_n,
  output logic                     usb_oe_n,
  output logic [7:0]               data,
  output logic                     valid,
  input  logic                     rd,
  output logic [FIFO_LOG_SIZE-1:0] level
);
  localparam int DEPTH = 1 << FIFO_LOG_SIZE;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STROBE = 2'd1;
  localparam logic [1:0] GAP    = 2'd2;

  localparam logic [7:0] PULSE_LOAD = 8'(RD_PULSE - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(RD_GAP - 1);

  logic [1:0]               state;
  logic [7:0]               cnt;
  logic [FIFO_LOG_SIZE-1:0] wr_ptr;
  logic [FIFO_LOG_SIZE-1:0] rd_ptr;
  logic [7:0]               mem [DEPTH];
  logic                     rxf;
  logic                     full;
  logic                     empty;
  logic                     capture;
  logic                     load;

`ifdef USBRX_SYNC_EN
  logic rxf_meta;
  logic rxf_sync;

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      rxf_meta <= 1'b1;
      rxf_sync <= 1'b1;
    end else begin
      rxf_meta <= usb_rxf_n;
      rxf_sync <= rxf_meta;
    end
  end

  assign rxf = rxf_sync;
`else
  assign rxf = usb_rxf_n;
`endif

  assign usb_oe_n = 1'b1;
  assign full     = (wr_ptr + FIFO_LOG_SIZE'(1)) == rd_ptr;
  assign empty    = wr_ptr == rd_ptr;
  assign level    = wr_ptr - rd_ptr;
  assign capture  = (state == STROBE) && (cnt == 8'd0);
  assign load     = (!valid || rd) && !empty;

  // Strobe FSM: full is only consulted in IDLE; a started strobe always has a free slot.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      usb_rd_n <= 1'b1;
      wr_ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rxf && !full) begin
            usb_rd_n <= 1'b0;
            cnt      <= PULSE_LOAD;
            state    <= STROBE;
          end
        end
        STROBE: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            usb_rd_n <= 1'b1;
            wr_ptr   <= wr_ptr + FIFO_LOG_SIZE'(1);
            cnt      <= GAP_LOAD;
            state    <= GAP;
          end
        end
        GAP: begin
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
          else             state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // usb_d is sampled on the edge that raises usb_rd_n, while the strobe is still low.
  always_ff @(posedge mclk) begin
    if (capture) mem[wr_ptr] <= usb_d;
  end

  // Output register stage
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      valid  <= 1'b0;
    end else if (load) begin
      rd_ptr <= rd_ptr + FIFO_LOG_SIZE'(1);
      valid  <= 1'b1;
    end else if (rd) begin
      valid  <= 1'b0;
    end
  end

  always_ff @(posedge mclk) begin
    if (load) data <= mem[rd_ptr];
  end

endmodule
